// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file write port between two requesters.
// Optional macro WB_BYPASS_EN adds combinational forwarding of the staged write onto two read ports.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Wb0_Valid_i,
    output logic              Wb0_Ready_o,
    input  logic [ADDR_W-1:0] Wb0_Addr_i,
    input  logic [DATA_W-1:0] Wb0_Data_i,
    input  logic              Wb1_Valid_i,
    output logic              Wb1_Ready_o,
    input  logic [ADDR_W-1:0] Wb1_Addr_i,
    input  logic [DATA_W-1:0] Wb1_Data_i,
    output logic              Reg_Write_o,
    output logic [ADDR_W-1:0] Write_Register_o,
    output logic [DATA_W-1:0] Write_Data_o,
    output logic              Busy_o,
    output logic [7:0]        Drop_Count_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] Rd1_Addr_i,
    input  logic [ADDR_W-1:0] Rd2_Addr_i,
    input  logic [DATA_W-1:0] Rd1_Data_i,
    input  logic [DATA_W-1:0] Rd2_Data_i,
    output logic [DATA_W-1:0] Rd1_Data_o,
    output logic [DATA_W-1:0] Rd2_Data_o
`endif
);

    logic              buf0_v_q, buf0_v_d, buf1_v_q, buf1_v_d;
    logic [ADDR_W-1:0] buf0_addr_q, buf0_addr_d, buf1_addr_q, buf1_addr_d;
    logic [DATA_W-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
    logic              rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [7:0]        drop_q, drop_d;

    logic       grant0, grant1;
    logic       acc0, acc1, drop0, drop1;
    logic [8:0] drop_sum;

    always_comb begin
        // rr_last_q high means port 1 won last, so port 0 takes the next tie
        grant0 = buf0_v_q & (~buf1_v_q | rr_last_q);
        grant1 = buf1_v_q & (~buf0_v_q | ~rr_last_q);

        Wb0_Ready_o = ~buf0_v_q | grant0;
        Wb1_Ready_o = ~buf1_v_q | grant1;

        acc0  = Wb0_Valid_i & Wb0_Ready_o;
        acc1  = Wb1_Valid_i & Wb1_Ready_o;
        drop0 = acc0 & (Wb0_Addr_i == '0);
        drop1 = acc1 & (Wb1_Addr_i == '0);

        buf0_v_d    = buf0_v_q & ~grant0;
        buf0_addr_d = buf0_addr_q;
        buf0_data_d = buf0_data_q;
        if (acc0 && !drop0) begin
            buf0_v_d    = 1'b1;
            buf0_addr_d = Wb0_Addr_i;
            buf0_data_d = Wb0_Data_i;
        end

        buf1_v_d    = buf1_v_q & ~grant1;
        buf1_addr_d = buf1_addr_q;
        buf1_data_d = buf1_data_q;
        if (acc1 && !drop1) begin
            buf1_v_d    = 1'b1;
            buf1_addr_d = Wb1_Addr_i;
            buf1_data_d = Wb1_Data_i;
        end

        rr_last_d = rr_last_q;
        we_d      = grant0 | grant1;
        wa_d      = wa_q;
        wd_d      = wd_q;
        if (grant0) begin
            rr_last_d = 1'b0;
            wa_d      = buf0_addr_q;
            wd_d      = buf0_data_q;
        end else if (grant1) begin
            rr_last_d = 1'b1;
            wa_d      = buf1_addr_q;
            wd_d      = buf1_data_q;
        end

        drop_sum = {1'b0, drop_q} + {8'd0, drop0} + {8'd0, drop1};
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0_v_q    <= 1'b0;
            buf0_addr_q <= '0;
            buf0_data_q <= '0;
            buf1_v_q    <= 1'b0;
            buf1_addr_q <= '0;
            buf1_data_q <= '0;
            rr_last_q   <= 1'b1;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            drop_q      <= '0;
        end else begin
            buf0_v_q    <= buf0_v_d;
            buf0_addr_q <= buf0_addr_d;
            buf0_data_q <= buf0_data_d;
            buf1_v_q    <= buf1_v_d;
            buf1_addr_q <= buf1_addr_d;
            buf1_data_q <= buf1_data_d;
            rr_last_q   <= rr_last_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            drop_q      <= drop_d;
        end
    end

    assign Reg_Write_o      = we_q;
    assign Write_Register_o = wa_q;
    assign Write_Data_o     = wd_q;
    assign Drop_Count_o     = drop_q;
    assign Busy_o           = buf0_v_q | buf1_v_q | we_q;

`ifdef WB_BYPASS_EN
    // Only the staged write is forwarded; register 0 always reads the file
    assign Rd1_Data_o = (we_q && (wa_q == Rd1_Addr_i) && (Rd1_Addr_i != '0)) ? wd_q : Rd1_Data_i;
    assign Rd2_Data_o = (we_q && (wa_q == Rd2_Addr_i) && (Rd2_Addr_i != '0)) ? wd_q : Rd2_Data_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed tables, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [AW-1:0] wb0_addr = '0, wb1_addr = '0;
    logic [DW-1:0] wb0_data = '0, wb1_data = '0;
    logic          wb0_ready, wb1_ready;
    logic          reg_write;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic          busy;
    logic [7:0]    drop_count;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] rd1_addr = '0, rd2_addr = '0;
    logic [DW-1:0] rd1_din = '0, rd2_din = '0;
    logic [DW-1:0] rd1_dout, rd2_dout;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .Wb0_Valid_i      (wb0_valid),
        .Wb0_Ready_o      (wb0_ready),
        .Wb0_Addr_i       (wb0_addr),
        .Wb0_Data_i       (wb0_data),
        .Wb1_Valid_i      (wb1_valid),
        .Wb1_Ready_o      (wb1_ready),
        .Wb1_Addr_i       (wb1_addr),
        .Wb1_Data_i       (wb1_data),
        .Reg_Write_o      (reg_write),
        .Write_Register_o (write_register),
        .Write_Data_o     (write_data),
        .Busy_o           (busy),
        .Drop_Count_o     (drop_count)
`ifdef WB_BYPASS_EN
        ,
        .Rd1_Addr_i       (rd1_addr),
        .Rd2_Addr_i       (rd2_addr),
        .Rd1_Data_i       (rd1_din),
        .Rd2_Data_i       (rd2_din),
        .Rd1_Data_o       (rd1_dout),
        .Rd2_Data_o       (rd2_dout)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-port one-entry holding slot, alternating winner on ties
    logic          m_v[2];
    logic [AW-1:0] m_a[2];
    logic [DW-1:0] m_d[2];
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_drop;
    logic          s_r1;

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0;
            m_a[k] = '0;
            m_d[k] = '0;
        end
        m_last = 1;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_drop = 0;
    endtask

    function automatic int m_winner();
        if (m_v[0] && m_v[1]) return (m_last == 0) ? 1 : 0;
        if (m_v[0]) return 0;
        if (m_v[1]) return 1;
        return -1;
    endfunction

    function automatic logic m_ready(input int k);
        return !m_v[k] || (m_winner() == k);
    endfunction

    task automatic m_step();
        logic          iv[2];
        logic [AW-1:0] ia[2];
        logic [DW-1:0] id[2];
        logic          r[2];
        int            w;
        int            drops;
        iv[0] = wb0_valid; ia[0] = wb0_addr; id[0] = wb0_data;
        iv[1] = wb1_valid; ia[1] = wb1_addr; id[1] = wb1_data;
        r[0] = m_ready(0);
        r[1] = m_ready(1);
        w = m_winner();
        drops = 0;
        if (w >= 0) begin
            m_we = 1'b1;
            m_wa = m_a[w];
            m_wd = m_d[w];
            m_v[w] = 1'b0;
            m_last = w;
        end else begin
            m_we = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (iv[k] && r[k]) begin
                if (ia[k] == '0) begin
                    drops++;
                end else begin
                    m_v[k] = 1'b1;
                    m_a[k] = ia[k];
                    m_d[k] = id[k];
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    endtask

    task automatic compare_all();
        chk("reg_write", 32'(reg_write), 32'(m_we));
        chk("write_register", 32'(write_register), 32'(m_wa));
        chk("write_data", write_data, m_wd);
        chk("busy", 32'(busy), 32'(m_v[0] | m_v[1] | m_we));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("wb0_ready", 32'(wb0_ready), 32'(m_ready(0)));
        chk("wb1_ready", 32'(wb1_ready), 32'(m_ready(1)));
`ifdef WB_BYPASS_EN
        chk("rd1_bypass", rd1_dout,
            (m_we && m_wa == rd1_addr && rd1_addr != '0) ? m_wd : rd1_din);
        chk("rd2_bypass", rd2_dout,
            (m_we && m_wa == rd2_addr && rd2_addr != '0) ? m_wd : rd2_din);
`endif
    endtask

    // Compare at the falling edge, advance the model, then return 1 time unit past the rise
    task automatic cycle();
        @(negedge clk);
        compare_all();
        s_r1 = wb1_ready;
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          r0;
        logic          r1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic v0, input int a0, input logic v1, input int a1,
                                 input logic we, input int wa, input logic [DW-1:0] wd,
                                 input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = 32'h100 + 32'(a0);
        v.v1 = v1; v.a1 = AW'(a1); v.d1 = 32'h100 + 32'(a1);
        v.we = we; v.wa = AW'(wa); v.wd = wd; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic apply_table(input string tag);
        foreach (tbl[i]) begin
            wb0_valid = tbl[i].v0; wb0_addr = tbl[i].a0; wb0_data = tbl[i].d0;
            wb1_valid = tbl[i].v1; wb1_addr = tbl[i].a1; wb1_data = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("%s[%0d].we", tag, i), 32'(reg_write), 32'(tbl[i].we));
            chk($sformatf("%s[%0d].wa", tag, i), 32'(write_register), 32'(tbl[i].wa));
            chk($sformatf("%s[%0d].wd", tag, i), write_data, tbl[i].wd);
            chk($sformatf("%s[%0d].r0", tag, i), 32'(wb0_ready), 32'(tbl[i].r0));
            chk($sformatf("%s[%0d].r1", tag, i), 32'(wb1_ready), 32'(tbl[i].r1));
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    logic          p_v[2];
    logic [AW-1:0] p_a[2];
    logic [DW-1:0] p_d[2];
    logic          acc[2];
    int            wait1, max_wait1;

    initial begin
        m_reset();
        do_reset();
        @(negedge clk);
        chk("reset.we", 32'(reg_write), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.drop", 32'(drop_count), 32'd0);
        chk("reset.wa", 32'(write_register), 32'd0);
        @(posedge clk);
        #1;

        // Single write: addr 5 visible for exactly one cycle, two edges after acceptance
        tbl.delete();
        tbl.push_back(mkv(1, 5, 0, 0, 0, 0, 32'h0, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1));
        tbl[0].d0 = 32'hDEADBEEF;
        apply_table("single");

        // Contention: writes retire 1,11,2,12,3,13,4,14 back to back
        do_reset();
        tbl.delete();
        tbl.push_back(mkv(1, 1, 1, 11, 0, 0, 32'h0, 1, 1));
        tbl.push_back(mkv(1, 2, 1, 11, 0, 0, 32'h0, 1, 0));
        tbl.push_back(mkv(1, 2, 1, 12, 1, 1, 32'h101, 0, 1));
        tbl.push_back(mkv(1, 3, 1, 12, 1, 11, 32'h10B, 1, 0));
        tbl.push_back(mkv(1, 3, 1, 13, 1, 2, 32'h102, 0, 1));
        tbl.push_back(mkv(1, 4, 1, 13, 1, 12, 32'h10C, 1, 0));
        tbl.push_back(mkv(1, 4, 1, 14, 1, 3, 32'h103, 0, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 13, 32'h10D, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 4, 32'h104, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 14, 32'h10E, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 14, 32'h10E, 1, 1));
        apply_table("contend");

        // Register 0 drops on port 1: never written, count saturates
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wb1_valid = 1'b1; wb1_addr = '0; wb1_data = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();
        chk("drop.saturated", 32'(drop_count), 32'd255);

        // Reset mid-stream with both buffers full and a drop recorded
        do_reset();
        wb0_valid = 1'b1; wb0_addr = '0; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_addr = 5'd3; wb1_data = 32'h33;
        cycle();
        wb0_addr = 5'd4; wb0_data = 32'h44;
        wb1_addr = 5'd6; wb1_data = 32'h66;
        cycle();
        idle_inputs();
        chk("pre_reset.busy", 32'(busy), 32'd1);
        chk("pre_reset.we", 32'(reg_write), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset.we", 32'(reg_write), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        repeat (4) cycle();

        // Backpressure: port 0 streams, port 1 stays valid; port 1 stalls at most one cycle
        do_reset();
        max_wait1 = 0;
        wait1 = 0;
        for (int k = 0; k < 2; k++) begin
            p_v[k] = 1'b1;
            p_a[k] = AW'($urandom_range(1, 31));
            p_d[k] = $urandom;
        end
        for (int i = 0; i < 60; i++) begin
            wb0_valid = p_v[0]; wb0_addr = p_a[0]; wb0_data = p_d[0];
            wb1_valid = p_v[1]; wb1_addr = p_a[1]; wb1_data = p_d[1];
            acc[0] = m_ready(0);
            acc[1] = m_ready(1);
            cycle();
            if (!s_r1) wait1++;
            else wait1 = 0;
            if (wait1 > max_wait1) max_wait1 = wait1;
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    p_a[k] = AW'($urandom_range(1, 31));
                    p_d[k] = $urandom;
                end
            end
        end
        idle_inputs();
        repeat (3) cycle();
        chk("backpressure.max_wait", 32'(max_wait1 <= 1), 32'd1);

        // Randomized protocol-compliant traffic with occasional register-0 writes
        do_reset();
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_v[k] && ($urandom_range(0, 3) != 0)) begin
                    p_v[k] = 1'b1;
                    p_a[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    p_d[k] = $urandom;
                end
            end
            wb0_valid = p_v[0]; wb0_addr = p_a[0]; wb0_data = p_d[0];
            wb1_valid = p_v[1]; wb1_addr = p_a[1]; wb1_data = p_d[1];
`ifdef WB_BYPASS_EN
            rd1_addr = ($urandom_range(0, 1) == 0) ? m_a[0] : AW'($urandom);
            rd2_addr = AW'($urandom);
            rd1_din  = $urandom;
            rd2_din  = $urandom;
`endif
            acc[0] = p_v[0] && m_ready(0);
            acc[1] = p_v[1] && m_ready(1);
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) p_v[k] = 1'b0;
            end
        end
        idle_inputs();
        repeat (4) cycle();

`ifdef WB_BYPASS_EN
        // Staged write to r7 is forwarded to read port 1; read port 2 at r0 is not
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1234;
        cycle();
        idle_inputs();
        cycle();
        rd1_addr = 5'd7; rd1_din = 32'h0;
        rd2_addr = 5'd0; rd2_din = 32'h5A5A;
        @(negedge clk);
        chk("bypass.rd1", rd1_dout, 32'h1234);
        chk("bypass.rd2", rd2_dout, 32'h5A5A);
        @(posedge clk);
        #1;
        chk("bypass.after", rd1_dout, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
